// File: rtl/hash_pkg.sv
// Shared encodings for the hash command sequencer: CU op codes, hash_op bit
// positions and the one-hot sequencer state set.
package hash_pkg;

  localparam logic [1:0] HOP_INIT = 2'b00;
  localparam logic [1:0] HOP_RUN  = 2'b01;
  localparam logic [1:0] HOP_LAST = 2'b10;
  localparam logic [1:0] HOP_CLR  = 2'b11;

  localparam int HOP_MAC_BIT = 3;
  localparam int HOP_384_BIT = 2;

  typedef enum logic [9:0] {
    S_IDLE   = 10'b00_0000_0001,
    S_INIT   = 10'b00_0000_0010,
    S_INIT_W = 10'b00_0000_0100,
    S_BREQ   = 10'b00_0000_1000,
    S_ISSUE  = 10'b00_0001_0000,
    S_OP_W   = 10'b00_0010_0000,
    S_NEXT   = 10'b00_0100_0000,
    S_CLR_W  = 10'b00_1000_0000,
    S_FIN    = 10'b01_0000_0000,
    S_FAIL   = 10'b10_0000_0000
  } state_e;

  function automatic logic [3:0] mk_op(input logic mac, input logic m384, input logic [1:0] op);
    logic [3:0] r;
    r = {2'b00, op};
    r[HOP_MAC_BIT] = mac;
    r[HOP_384_BIT] = m384;
    return r;
  endfunction

endpackage

// File: rtl/hash_seq_wdog.sv
// Per-op watchdog: loaded on every CU strobe, counts while a CU response is
// awaited, saturates at TMO_MAX and flags expiry there.
module hash_seq_wdog
  import hash_pkg::*;
#(
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}}
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // The strobe cycle itself counts as the first waited cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = TMO_W'(1);
    end else if (cnt_en_i && (cnt_q != TMO_MAX)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == TMO_MAX);

endmodule

// File: rtl/hash_seq.sv
// Hash job sequencer: fetches message blocks and drives the INIT/RUN/LAST op
// stream into the hash CU, with abort and watchdog recovery through CLR.
module hash_seq
  import hash_pkg::*;
#(
  parameter int               NBLK_W  = 8,
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mac,
  input  logic              cmd_384,
  input  logic [NBLK_W-1:0] cmd_nblk,
  input  logic              cmd_abort,
  output logic              blk_req,
  input  logic              blk_ack,
  output logic [NBLK_W-1:0] blk_idx,
  output logic [3:0]        hash_op,
  output logic              hash_en,
  output logic              hash_clr,
  input  logic              hash_rdy,
  input  logic              hash_done,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err
);

  state_e            state_q, state_d;
  logic [NBLK_W-1:0] blk_idx_q, blk_idx_d, nblk_q, nblk_d;
  logic              mac_q, mac_d, m384_q, m384_d;
  logic [3:0]        hash_op_q, hash_op_d;
  logic              hash_en_q, hash_en_d, hash_clr_q, hash_clr_d;
  logic              pend_q, pend_d;
  logic              blk_req_q, cmd_ready_q, seq_busy_q, seq_done_q, seq_err_q;
  logic              seq_done_d, seq_err_d;
  logic              go_clr, abort_req, tmo, in_w, is_last;

  assign in_w      = (state_q == S_INIT_W) || (state_q == S_OP_W) || (state_q == S_CLR_W);
  assign is_last   = (blk_idx_q == nblk_q - NBLK_W'(1));
  assign abort_req = cmd_abort || pend_q;

  hash_seq_wdog #(.TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .load_i    (hash_en_d | hash_clr_d),
    .cnt_en_i  (in_w),
    .expired_o (tmo)
  );

  always_comb begin
    state_d    = state_q;
    blk_idx_d  = blk_idx_q;
    nblk_d     = nblk_q;
    mac_d      = mac_q;
    m384_d     = m384_q;
    hash_op_d  = hash_op_q;
    hash_en_d  = 1'b0;
    hash_clr_d = 1'b0;
    seq_done_d = 1'b0;
    seq_err_d  = 1'b0;
    pend_d     = 1'b0;
    go_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          mac_d     = cmd_mac;
          m384_d    = cmd_384;
          nblk_d    = cmd_nblk;
          blk_idx_d = '0;
          state_d   = (cmd_nblk == '0) ? S_FAIL : S_INIT;
        end
      end
      S_INIT: begin
        if (abort_req) go_clr = 1'b1;
        else if (hash_rdy) begin
          hash_en_d = 1'b1;
          hash_op_d = mk_op(mac_q, m384_q, HOP_INIT);
          state_d   = S_INIT_W;
        end
      end
      // An abort landing on the strobe cycle is held one cycle so CLR never abuts EN.
      S_INIT_W: begin
        if (hash_en_q && cmd_abort) pend_d = 1'b1;
        else if (abort_req)         go_clr = 1'b1;
        else if (hash_done)         state_d = S_BREQ;
        else if (tmo)               go_clr = 1'b1;
      end
      S_BREQ: begin
        if (abort_req)    go_clr = 1'b1;
        else if (blk_ack) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort_req) go_clr = 1'b1;
        else if (hash_rdy) begin
          hash_en_d = 1'b1;
          hash_op_d = mk_op(mac_q, m384_q, is_last ? HOP_LAST : HOP_RUN);
          state_d   = S_OP_W;
        end
      end
      S_OP_W: begin
        if (hash_en_q && cmd_abort) pend_d = 1'b1;
        else if (abort_req)         go_clr = 1'b1;
        else if (hash_done)         state_d = S_NEXT;
        else if (tmo)               go_clr = 1'b1;
      end
      S_NEXT: begin
        if (abort_req)    go_clr = 1'b1;
        else if (is_last) state_d = S_FIN;
        else begin
          blk_idx_d = blk_idx_q + NBLK_W'(1);
          state_d   = S_BREQ;
        end
      end
      S_CLR_W: begin
        if (hash_done || tmo) state_d = S_FAIL;
      end
      S_FIN: begin
        seq_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_FAIL: begin
        seq_err_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (go_clr) begin
      hash_clr_d = 1'b1;
      hash_op_d  = mk_op(mac_q, m384_q, HOP_CLR);
      state_d    = S_CLR_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      blk_idx_q   <= '0;
      nblk_q      <= '0;
      mac_q       <= 1'b0;
      m384_q      <= 1'b0;
      hash_op_q   <= '0;
      hash_en_q   <= 1'b0;
      hash_clr_q  <= 1'b0;
      pend_q      <= 1'b0;
      blk_req_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      seq_busy_q  <= 1'b0;
      seq_done_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_idx_q   <= blk_idx_d;
      nblk_q      <= nblk_d;
      mac_q       <= mac_d;
      m384_q      <= m384_d;
      hash_op_q   <= hash_op_d;
      hash_en_q   <= hash_en_d;
      hash_clr_q  <= hash_clr_d;
      pend_q      <= pend_d;
      blk_req_q   <= (state_d == S_BREQ);
      cmd_ready_q <= (state_d == S_IDLE);
      seq_busy_q  <= (state_d != S_IDLE);
      seq_done_q  <= seq_done_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign blk_req   = blk_req_q;
  assign blk_idx   = blk_idx_q;
  assign hash_op   = hash_op_q;
  assign hash_en   = hash_en_q;
  assign hash_clr  = hash_clr_q;
  assign seq_busy  = seq_busy_q;
  assign seq_done  = seq_done_q;
  assign seq_err   = seq_err_q;

endmodule
